// File: rtl/axi4_rd_sched.sv
// Read-channel scheduler: arbitrates IF/MEM onto one AXI4 read master, one burst at a time.
// Optional IF anti-starvation guard enabled by defining AXI_RD_STARVE_GUARD_EN.
module axi4_rd_sched #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  input  logic [XLEN-1:0] if_req_addr,
  input  logic [3:0]      if_req_size,
  input  logic [7:0]      if_req_len,
  output logic            if_grant,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_rvalid,
  output logic            if_rlast,
  input  logic            mem_req_valid,
  input  logic [XLEN-1:0] mem_req_addr,
  input  logic [3:0]      mem_req_size,
  input  logic [7:0]      mem_req_len,
  output logic            mem_grant,
  output logic [XLEN-1:0] mem_rdata,
  output logic            mem_rvalid,
  output logic            mem_rlast,
  input  logic            wr_busy_i,
  input  logic [XLEN-1:0] wr_addr_i,
  output logic            ar_valid,
  output logic [XLEN-1:0] ar_addr,
  output logic [3:0]      ar_size,
  output logic [7:0]      ar_len,
  input  logic            ar_ready,
  input  logic [XLEN-1:0] r_data,
  input  logic            r_valid,
  input  logic            r_last,
  output logic            r_ready,
  output logic [1:0]      owner
);

  // Handshakes: AR transfers when ar_valid && ar_ready; R beats transfer when r_valid && r_ready.
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_MEM  = 2'b10;

  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
    $error("axi4_rd_sched: STARVE_MAX must be in 1..15");
  end

  state_t state, state_nxt;
  logic   if_elig, mem_elig, if_force, pick_if, pick_mem;
  logic   unused_wr_low;

  assign unused_wr_low = ^wr_addr_i[1:0];

  // Hazard compares word addresses only; the byte offset is ignored.
  always_comb begin
    if_elig  = if_req_valid &&
               !(wr_busy_i && (if_req_addr[XLEN-1:2] == wr_addr_i[XLEN-1:2]));
    mem_elig = mem_req_valid &&
               !(wr_busy_i && (mem_req_addr[XLEN-1:2] == wr_addr_i[XLEN-1:2]));
  end

`ifdef AXI_RD_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign if_force = if_elig && (starve_cnt == 4'(STARVE_MAX));

  // Counts MEM wins that left an eligible IF waiting.
  always_ff @(posedge clk) begin
    if (rst)                     starve_cnt <= '0;
    else if (pick_if)            starve_cnt <= '0;
    else if (pick_mem && if_elig) starve_cnt <= starve_cnt + 4'd1;
  end
`else
  assign if_force = 1'b0;
`endif

  always_comb begin
    pick_mem = (state == IDLE) && !rst && mem_elig && !if_force;
    pick_if  = (state == IDLE) && !rst && if_elig && (if_force || !mem_elig);
  end

  assign if_grant  = pick_if;
  assign mem_grant = pick_mem;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_if || pick_mem)  state_nxt = ADDR;
      ADDR:    if (ar_ready)             state_nxt = DATA;
      DATA:    if (r_valid && r_last)    state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_addr <= '0;
      ar_size <= '0;
      ar_len  <= '0;
      owner   <= OWN_NONE;
    end else if (pick_mem) begin
      ar_addr <= mem_req_addr;
      ar_size <= mem_req_size;
      ar_len  <= mem_req_len;
      owner   <= OWN_MEM;
    end else if (pick_if) begin
      ar_addr <= if_req_addr;
      ar_size <= if_req_size;
      ar_len  <= if_req_len;
      owner   <= OWN_IF;
    end else if ((state == DATA) && r_valid && r_last) begin
      owner   <= OWN_NONE;
    end
  end

  assign ar_valid = (state == ADDR);
  assign r_ready  = (state == DATA);

  // Beats are steered to the owner only while in DATA; everyone else sees zeros.
  always_comb begin
    if_rdata   = '0;
    if_rvalid  = 1'b0;
    if_rlast   = 1'b0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    if (state == DATA) begin
      if (owner == OWN_IF) begin
        if_rdata  = r_data;
        if_rvalid = r_valid;
        if_rlast  = r_valid && r_last;
      end else if (owner == OWN_MEM) begin
        mem_rdata  = r_data;
        mem_rvalid = r_valid;
        mem_rlast  = r_valid && r_last;
      end
    end
  end

endmodule

// File: tb/tb_axi4_rd_sched.sv
// Directed bench for axi4_rd_sched: single burst, arbitration, write hazard,
// starvation pattern (depends on AXI_RD_STARVE_GUARD_EN) and mid-burst reset.
module tb_axi4_rd_sched;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req_valid, mem_req_valid;
  logic [XLEN-1:0] if_req_addr, mem_req_addr;
  logic [3:0]      if_req_size, mem_req_size;
  logic [7:0]      if_req_len, mem_req_len;
  logic            if_grant, mem_grant;
  logic [XLEN-1:0] if_rdata, mem_rdata;
  logic            if_rvalid, mem_rvalid, if_rlast, mem_rlast;
  logic            wr_busy_i;
  logic [XLEN-1:0] wr_addr_i;
  logic            ar_valid, ar_ready;
  logic [XLEN-1:0] ar_addr;
  logic [3:0]      ar_size;
  logic [7:0]      ar_len;
  logic [XLEN-1:0] r_data;
  logic            r_valid, r_last, r_ready;
  logic [1:0]      owner;

  int errors = 0;
  int checks = 0;

  axi4_rd_sched #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_req_size(if_req_size), .if_req_len(if_req_len),
    .if_grant(if_grant), .if_rdata(if_rdata), .if_rvalid(if_rvalid), .if_rlast(if_rlast),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_size(mem_req_size), .mem_req_len(mem_req_len),
    .mem_grant(mem_grant), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_rlast(mem_rlast),
    .wr_busy_i(wr_busy_i), .wr_addr_i(wr_addr_i),
    .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_size(ar_size), .ar_len(ar_len),
    .ar_ready(ar_ready), .r_data(r_data), .r_valid(r_valid), .r_last(r_last),
    .r_ready(r_ready), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One R beat in DATA; to_if selects which requester must receive it.
  task automatic beat(input logic to_if, input logic [31:0] d, input logic last);
    r_valid = 1'b1;
    r_data  = d;
    r_last  = last;
    #1;
    check("rvalid_if",  32'(if_rvalid),  32'(to_if));
    check("rvalid_mem", 32'(mem_rvalid), 32'(!to_if));
    check("rdata_own",  to_if ? if_rdata : mem_rdata, d);
    check("rdata_oth",  to_if ? mem_rdata : if_rdata, 32'h0);
    check("rlast_own",  32'(to_if ? if_rlast : mem_rlast), 32'(last));
    step();
    r_valid = 1'b0;
    r_last  = 1'b0;
  endtask

  // ADDR phase with ar_ready on the first cycle, then one single-beat burst.
  task automatic finish_single(input logic to_if, input logic [31:0] d);
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    beat(to_if, d, 1'b1);
  endtask

  initial begin
    logic [1:0] exp_arb;
    rst = 1'b1;
    if_req_valid = 0; if_req_addr = 0; if_req_size = 0; if_req_len = 0;
    mem_req_valid = 0; mem_req_addr = 0; mem_req_size = 0; mem_req_len = 0;
    wr_busy_i = 0; wr_addr_i = 0; ar_ready = 0; r_data = 0; r_valid = 0; r_last = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ar_valid", 32'(ar_valid), 32'h0);
    check("rst_ar_addr",  ar_addr, 32'h0);
    check("rst_ar_len",   32'(ar_len), 32'h0);
    check("rst_owner",    32'(owner), 32'h0);
    check("rst_r_ready",  32'(r_ready), 32'h0);
    check("rst_grants",   {30'h0, if_grant, mem_grant}, 32'h0);

    // Single IF burst, len 3, ar_ready after two ADDR cycles.
    if_req_valid = 1; if_req_addr = 32'h8000_0000; if_req_size = 4'd2; if_req_len = 8'd3;
    #1;
    check("t1_if_grant",  32'(if_grant), 32'h1);
    check("t1_mem_grant", 32'(mem_grant), 32'h0);
    step();
    if_req_valid = 0; r_valid = 1; r_last = 1;
    #1;
    check("t1_ar_valid1", 32'(ar_valid), 32'h1);
    check("t1_ar_addr",   ar_addr, 32'h8000_0000);
    check("t1_ar_len",    32'(ar_len), 32'h3);
    check("t1_ar_size",   32'(ar_size), 32'h2);
    check("t1_owner",     32'(owner), 32'h1);
    check("t1_no_fwd",    32'(if_rvalid), 32'h0);
    check("t1_rready_ad", 32'(r_ready), 32'h0);
    step();
    r_valid = 0; r_last = 0; ar_ready = 1;
    #1;
    check("t1_ar_valid2", 32'(ar_valid), 32'h1);
    step();
    ar_ready = 0;
    #1;
    check("t1_ar_valid3", 32'(ar_valid), 32'h0);
    check("t1_r_ready",   32'(r_ready), 32'h1);
    for (int i = 0; i < 4; i++) beat(1'b1, 32'h1000 + i, (i == 3));
    #1;
    check("t1_owner_end", 32'(owner), 32'h0);
    check("t1_rready_end", 32'(r_ready), 32'h0);

    // IF and MEM together: MEM first, IF right after MEM's last beat.
    mem_req_valid = 1; mem_req_addr = 32'h200; mem_req_len = 0;
    if_req_valid = 1;  if_req_addr = 32'h300;  if_req_len = 0;
    #1;
    check("t2_mem_grant", 32'(mem_grant), 32'h1);
    check("t2_if_wait",   32'(if_grant), 32'h0);
    step();
    mem_req_valid = 0;
    #1;
    check("t2_owner_mem", 32'(owner), 32'h2);
    check("t2_ar_addr",   ar_addr, 32'h200);
    check("t2_if_busy",   32'(if_grant), 32'h0);
    finish_single(1'b0, 32'hAAAA_0001);
    #1;
    check("t2_if_grant",  32'(if_grant), 32'h1);
    step();
    if_req_valid = 0;
    #1;
    check("t2_ar_addr_if", ar_addr, 32'h300);
    finish_single(1'b1, 32'hBBBB_0002);

    // MEM hazarded by write at 0x102: IF goes first, MEM once the write clears.
    wr_busy_i = 1; wr_addr_i = 32'h102;
    mem_req_valid = 1; mem_req_addr = 32'h100;
    if_req_valid = 1;  if_req_addr = 32'h400;
    #1;
    check("t3_if_grant",  32'(if_grant), 32'h1);
    check("t3_mem_block", 32'(mem_grant), 32'h0);
    step();
    if_req_valid = 0;
    wr_busy_i = 0;
    finish_single(1'b1, 32'hC0DE_0003);
    #1;
    check("t3_mem_grant", 32'(mem_grant), 32'h1);
    step();
    mem_req_valid = 0;
    finish_single(1'b0, 32'hC0DE_0004);

    // IF alone hazarded: no grant; a clean MEM request is not blocked by it.
    wr_busy_i = 1; wr_addr_i = 32'h400;
    if_req_valid = 1; if_req_addr = 32'h403;
    #1;
    check("t3_if_haz", {30'h0, if_grant, mem_grant}, 32'h0);
    mem_req_valid = 1; mem_req_addr = 32'h800;
    #1;
    check("t3_mem_pass", {30'h0, if_grant, mem_grant}, 32'h1);
    step();
    mem_req_valid = 0; if_req_valid = 0; wr_busy_i = 0;
    finish_single(1'b0, 32'hC0DE_0005);

    // Continuous contention with single-beat bursts.
    mem_req_valid = 1; mem_req_addr = 32'h900;
    if_req_valid = 1;  if_req_addr = 32'hA00;
    for (int k = 0; k < 10; k++) begin
`ifdef AXI_RD_STARVE_GUARD_EN
      exp_arb = ((k % 5) == 4) ? 2'b10 : 2'b01;
`else
      exp_arb = 2'b01;
`endif
      #1;
      check("t4_arb", {30'h0, if_grant, mem_grant}, 32'(exp_arb));
      step();
      finish_single(exp_arb[1], 32'hD000 + k);
    end
    mem_req_valid = 0; if_req_valid = 0;

    // Reset on the 2nd beat of a len-7 IF burst.
    if_req_valid = 1; if_req_addr = 32'h600; if_req_len = 8'd7;
    #1;
    check("t5_if_grant", 32'(if_grant), 32'h1);
    step();
    if_req_valid = 0;
    ar_ready = 1;
    step();
    ar_ready = 0;
    beat(1'b1, 32'hE000, 1'b0);
    r_valid = 1; r_data = 32'hE001; rst = 1;
    #1;
    check("t5_beat2", 32'(if_rvalid), 32'h1);
    step();
    rst = 0;
    #1;
    check("t5_if_rvalid",  32'(if_rvalid), 32'h0);
    check("t5_mem_rvalid", 32'(mem_rvalid), 32'h0);
    check("t5_if_rdata",   if_rdata, 32'h0);
    check("t5_owner",      32'(owner), 32'h0);
    check("t5_r_ready",    32'(r_ready), 32'h0);
    check("t5_ar_valid",   32'(ar_valid), 32'h0);
    check("t5_ar_addr",    ar_addr, 32'h0);
    check("t5_ar_len",     32'(ar_len), 32'h0);
    step();
    #1;
    check("t5_if_rvalid2", 32'(if_rvalid), 32'h0);
    r_valid = 0;
    if_req_valid = 1; if_req_addr = 32'h700; if_req_len = 8'd0;
    #1;
    check("t5_regrant", 32'(if_grant), 32'h1);
    step();
    if_req_valid = 0;
    #1;
    check("t5_ar_addr_new", ar_addr, 32'h700);
    finish_single(1'b1, 32'hF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi4_rd_sched.md
# axi4_rd_sched

Read-channel scheduler that shares the single AXI4 read master between the instruction-fetch (IF) and memory-stage (MEM) requesters. It grants one burst at a time, drives AR, routes R beats back to the owner until `r_last`, and blocks reads that hit the address of an in-flight write. It sits between the fetch/LSU request ports and the AXI4 master read channel, beside the write path.

## Interface
- `XLEN`, 32, address/data width
- `STARVE_MAX`, 4, consecutive MEM grants allowed while IF waits (used only with `AXI_RD_STARVE_GUARD_EN`); legal range 1..15

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `if_req_valid`  in  1  IF read request; held with fields stable until `if_grant`
- `if_req_addr`  in  XLEN  IF address
- `if_req_size`  in  4  IF beat size code
- `if_req_len`  in  8  IF burst length minus one
- `if_grant`  out  1  one-cycle pulse: IF request captured
- `if_rdata`  out  XLEN  read beat data to IF
- `if_rvalid`  out  1  beat valid to IF
- `if_rlast`  out  1  final beat to IF
- `mem_req_valid`, `mem_req_addr`, `mem_req_size`, `mem_req_len`, `mem_grant`, `mem_rdata`, `mem_rvalid`, `mem_rlast`: same as the IF ports, for MEM
- `wr_busy_i`  in  1  write burst outstanding on the write path
- `wr_addr_i`  in  XLEN  address of the outstanding write
- `ar_valid`  out  1  AXI AR valid
- `ar_addr`  out  XLEN  AR address
- `ar_size`  out  4  AR size
- `ar_len`  out  8  AR length
- `ar_ready`  in  1  AXI AR ready
- `r_data`  in  XLEN  AXI R data
- `r_valid`  in  1  AXI R valid
- `r_last`  in  1  AXI R last
- `r_ready`  out  1  AXI R ready
- `owner`  out  2  00 none, 01 IF, 10 MEM

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: determine the eligible requesters. A requester is eligible when its `req_valid` is high and it is not hazarded.
  - Hazard: `wr_busy_i` is high and `req_addr[XLEN-1:2] == wr_addr_i[XLEN-1:2]`. This check applies to both IF and MEM.
  - Winner: MEM by default, else IF.
  - On a win: pulse that requester's grant, register addr, size and len into the `ar_*` outputs, set `owner`, and go to ADDR.
  - A hazarded requester never blocks the other requester.
- ADDR: `ar_valid`=1. AR fields stay stable until `ar_valid && ar_ready`, then go to DATA with `ar_valid`=0.
- DATA: `r_ready`=1.
  - Each `r_valid` beat is forwarded combinationally to the owner's `rdata`, `rvalid` and `rlast`.
  - The non-owner's `rvalid` and `rlast` are 0. Its `rdata` is 0.
  - On `r_valid && r_last`, go to IDLE and clear `owner`.
- `r_ready`=0 outside DATA. Beats arriving outside DATA are not forwarded.
- No beat counting: termination is by `r_last` only.

## Timing
- Reset: state IDLE, `ar_valid`=0, `ar_addr`/`ar_size`/`ar_len`=0, `owner`=00, all grants/rvalid/rlast=0, `r_ready`=0, starvation counter 0.
- Reset mid-burst: abandons the burst immediately. The cycle after reset deasserts is IDLE with no stale forwarding.
- Request to `ar_valid`:
  - A request valid in IDLE at cycle N gets its grant in cycle N.
  - `ar_valid` is high from N+1.
- Earliest next grant is the cycle after the `r_last` beat, with state IDLE.
- Simultaneous `ar_ready` on the first ADDR cycle: DATA at N+2. `r_valid` in that same cycle is ignored, which is legal per AXI since R follows AR.
- `wr_busy_i` is sampled only in IDLE. A write starting after the grant does not affect a granted read.
- A requester dropping `req_valid` before its grant is allowed: no grant is issued.

## Configuration
- `AXI_RD_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each MEM grant made while IF was eligible.
  - The counter clears on any IF grant.
  - When counter == `STARVE_MAX` and IF is eligible, IF wins the next arbitration regardless of MEM.
- Undefined: fixed MEM-over-IF priority, no counter; `STARVE_MAX` is ignored.

## Test plan
- Single IF request, addr 0x8000_0000, len 3; `ar_ready` after 2 cycles, 4 beats -> `if_grant` at N, `ar_valid` N+1..N+2, 4 `if_rvalid` pulses, `if_rlast` on the 4th, `owner` 00 the cycle after.
- IF and MEM both valid in IDLE -> MEM granted first. IF is granted the cycle after MEM's `r_last`, and IF sees no MEM beats.
- MEM addr 0x100 with `wr_busy_i`=1 and `wr_addr_i`=0x102, IF also valid -> IF granted. Once `wr_busy_i` drops, MEM is granted.
- With guard, `STARVE_MAX`=4, MEM and IF continuously valid, single-beat bursts -> grant order M,M,M,M,I,M,M,M,M,I. Without the macro: all M.
- `rst` asserted during the 2nd beat of a len-7 burst -> all outputs take their reset values the next cycle, with no further `rvalid` to either requester. A new IF request is then granted normally.
